// File: rtl/kbonacci_gen.sv
// Order-N additive recurrence stream source: each term is the sum of the previous ORDER terms.
// Latency: first term valid 1 cycle after start is sampled; one term per cycle while s_ready is high.
// Backpressure: s_valid/s_ready; without an accepted beat every output holds stable.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, abort      begin (sampled in IDLE) / terminate (sampled in RUN) a sequence
//   len               number of terms to emit, latched on start
//   seed_we/idx/data  seed register write port, honoured in IDLE only
//   s_valid/ready     output handshake; s_data/s_index/s_last describe the current term
//   busy, done        busy is high in RUN; done pulses once on normal completion
//   overflow          sticky flag: some sum needed more than WIDTH bits (cleared by start)
//
// Build option: define KBONACCI_SAT_EN to saturate overflowing sums to all-ones
// instead of wrapping modulo 2^WIDTH.

module kbonacci_gen #(
    parameter int WIDTH = 32,
    parameter int ORDER = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] len,
    input  logic             seed_we,
    input  logic [2:0]       seed_idx,
    input  logic [WIDTH-1:0] seed_data,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [WIDTH-1:0] s_data,
    output logic [CNT_W-1:0] s_index,
    output logic             s_last,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TERM_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LEN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] seed    [ORDER];
    logic [WIDTH-1:0] seed_nx [ORDER];
    logic [WIDTH-1:0] w       [ORDER];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    logic [WIDTH+2:0] sum_full;
    logic             sum_ovf;
    logic [WIDTH-1:0] next_term;
    logic             beat;

    // Seed bank as it will look after this cycle's write. Used both to update the
    // bank and to load the window, so a write coinciding with start is seen by
    // the new sequence. Slots >= ORDER simply never match.
    always_comb begin
        seed_nx = seed;
        for (int i = 0; i < ORDER; i++) begin
            if (seed_we && (state == IDLE) && (seed_idx == 3'(i))) begin
                seed_nx[i] = seed_data;
            end
        end
    end

    // Three guard bits cover the sum of up to eight WIDTH-bit terms.
    always_comb begin
        sum_full = '0;
        for (int i = 0; i < ORDER; i++) begin
            sum_full = sum_full + {3'b000, w[i]};
        end
    end

    assign sum_ovf = |sum_full[WIDTH+2:WIDTH];

`ifdef KBONACCI_SAT_EN
    assign next_term = sum_ovf ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    assign next_term = sum_full[WIDTH-1:0];
`endif

    assign beat    = valid_q & s_ready;
    assign cnt_inc = cnt + LEN_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            for (int i = 0; i < ORDER; i++) begin
                seed[i] <= (i == 0) ? '0 : TERM_ONE;
                w[i]    <= (i == 0) ? '0 : TERM_ONE;
            end
            cnt     <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    seed <= seed_nx;
                    if (start) begin
                        ovf_q <= 1'b0;
                        if (len != '0) begin
                            w       <= seed_nx;
                            cnt     <= '0;
                            len_q   <= len;
                            last_q  <= (len == LEN_ONE);
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state   <= RUN;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                RUN: begin
                    // A beat coinciding with abort is still delivered, so the
                    // window advances before the abort takes effect.
                    if (beat) begin
                        for (int i = 0; i < ORDER - 1; i++) begin
                            w[i] <= w[i+1];
                        end
                        w[ORDER-1] <= next_term;
                        cnt        <= cnt_inc;
                        last_q     <= (cnt_inc == (len_q - LEN_ONE));
                        if (sum_ovf) begin
                            ovf_q <= 1'b1;
                        end
                    end
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (beat && last_q) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign s_valid  = valid_q;
    assign s_data   = w[0];
    assign s_index  = cnt;
    assign s_last   = last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_kbonacci_gen.sv
// Bench for kbonacci_gen: three instances (32b/order3, 32b/order2, 8b/order3) share
// the handshake inputs; start and seed_we are steered to one instance at a time.
// Expected terms come from a plain integer recurrence over a seed model.
`timescale 1ns/1ps

module tb_kbonacci_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  seed_we_v;
    logic        abort;
    logic [15:0] len;
    logic [2:0]  seed_idx;
    logic [31:0] seed_data;
    logic        s_ready;

    logic [2:0]  v, lst, bsy, dn, ov;
    logic [31:0] d0, d1;
    logic [7:0]  d2;
    logic [15:0] ix0, ix1, ix2;

    kbonacci_gen #(.WIDTH(32), .ORDER(3), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .len(len),
        .seed_we(seed_we_v[0]), .seed_idx(seed_idx), .seed_data(seed_data),
        .s_valid(v[0]), .s_ready(s_ready), .s_data(d0), .s_index(ix0),
        .s_last(lst[0]), .busy(bsy[0]), .done(dn[0]), .overflow(ov[0]));

    kbonacci_gen #(.WIDTH(32), .ORDER(2), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .len(len),
        .seed_we(seed_we_v[1]), .seed_idx(seed_idx), .seed_data(seed_data),
        .s_valid(v[1]), .s_ready(s_ready), .s_data(d1), .s_index(ix1),
        .s_last(lst[1]), .busy(bsy[1]), .done(dn[1]), .overflow(ov[1]));

    kbonacci_gen #(.WIDTH(8), .ORDER(3), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .len(len),
        .seed_we(seed_we_v[2]), .seed_idx(seed_idx), .seed_data(seed_data[7:0]),
        .s_valid(v[2]), .s_ready(s_ready), .s_data(d2), .s_index(ix2),
        .s_last(lst[2]), .busy(bsy[2]), .done(dn[2]), .overflow(ov[2]));

    int ord_of [3] = '{3, 2, 3};
    int wid_of [3] = '{32, 32, 8};

    // Observed view of the currently selected instance.
    int          cur;
    logic        o_valid, o_last, o_busy, o_done, o_ovf;
    logic [31:0] o_data;
    logic [15:0] o_index;

    always_comb begin
        o_valid = v[cur];
        o_last  = lst[cur];
        o_busy  = bsy[cur];
        o_done  = dn[cur];
        o_ovf   = ov[cur];
        case (cur)
            0:       begin o_data = d0;          o_index = ix0; end
            1:       begin o_data = d1;          o_index = ix1; end
            default: begin o_data = {24'b0, d2}; o_index = ix2; end
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: seed bank per instance, and the expected term list.
    longint unsigned seed_m [3][8];
    longint unsigned exp_t  [128];
    bit              exp_ob [128];
    bit              exp_end;

    task automatic reset_model();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 8; i++)
                seed_m[s][i] = (i == 0) ? 0 : 1;
    endtask

    task automatic build_model(input int sel, input int n);
        longint unsigned maxv, sum;
        bit acc;
        maxv = (64'd1 << wid_of[sel]) - 1;
        for (int i = 0; i < ord_of[sel]; i++) exp_t[i] = seed_m[sel][i];
        acc = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_ob[k] = acc;
            sum = 0;
            for (int j = 0; j < ord_of[sel]; j++) sum += exp_t[k+j];
            if (sum > maxv) begin
                acc = 1'b1;
`ifdef KBONACCI_SAT_EN
                exp_t[k+ord_of[sel]] = maxv;
`else
                exp_t[k+ord_of[sel]] = sum & maxv;
`endif
            end else begin
                exp_t[k+ord_of[sel]] = sum;
            end
        end
        exp_end = acc;
    endtask

    task automatic write_seed(input int sel, input int idx, input logic [31:0] dat);
        seed_we_v[sel] = 1'b1;
        seed_idx       = 3'(idx);
        seed_data      = dat;
        @(negedge clk);
        seed_we_v = '0;
        if (idx < ord_of[sel]) seed_m[sel][idx] = dat & ((64'd1 << wid_of[sel]) - 1);
    endtask

    // Runs one full sequence on instance sel. rdy_pct sets s_ready density; noise
    // holds start/seed_we high during RUN; co_wr writes a seed in the start cycle.
    task automatic run_seq(input int sel, input int n, input int rdy_pct, input bit noise,
                           input bit co_wr, input int cw_idx, input logic [31:0] cw_dat);
        int k;
        int cyc;
        cur = sel;
        if (co_wr) begin
            seed_we_v[sel] = 1'b1;
            seed_idx       = 3'(cw_idx);
            seed_data      = cw_dat;
            if (cw_idx < ord_of[sel]) seed_m[sel][cw_idx] = cw_dat & ((64'd1 << wid_of[sel]) - 1);
        end
        build_model(sel, n);
        len          = 16'(n);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v   = '0;
        seed_we_v = '0;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 4 * n + 20) begin
            n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid sel=%0d k=%0d got %b want 1", sel, k, o_valid); end
            n_chk++; if (o_data !== 32'(exp_t[k])) begin n_fail++; $display("FAIL run_data sel=%0d k=%0d got %0d want %0d", sel, k, o_data, exp_t[k]); end
            n_chk++; if (o_index !== 16'(k)) begin n_fail++; $display("FAIL run_index sel=%0d got %0d want %0d", sel, o_index, k); end
            n_chk++; if (o_last !== (k == n - 1)) begin n_fail++; $display("FAIL run_last sel=%0d k=%0d got %b want %b", sel, k, o_last, (k == n - 1)); end
            n_chk++; if (o_ovf !== exp_ob[k]) begin n_fail++; $display("FAIL run_ovf sel=%0d k=%0d got %b want %b", sel, k, o_ovf, exp_ob[k]); end
            n_chk++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL run_busy_done sel=%0d k=%0d got busy=%b done=%b want 1/0", sel, k, o_busy, o_done); end
            s_ready = ($urandom_range(99) < rdy_pct);
            if (noise) begin
                start_v[sel]   = 1'b1;
                len            = 16'($urandom_range(1, 5));
                seed_we_v[sel] = 1'b1;
                seed_idx       = 3'($urandom_range(7));
                seed_data      = $urandom;
            end
            if (o_valid && s_ready) k++;
            @(negedge clk);
            cyc++;
        end
        start_v   = '0;
        seed_we_v = '0;
        n_chk++; if (k != n) begin n_fail++; $display("FAIL run_timeout sel=%0d got %0d beats want %0d", sel, k, n); end
        n_chk++; if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL end_done sel=%0d got done=%b valid=%b busy=%b want 1/0/0", sel, o_done, o_valid, o_busy); end
        n_chk++; if (o_ovf !== exp_end) begin n_fail++; $display("FAIL end_ovf sel=%0d got %b want %b", sel, o_ovf, exp_end); end
        @(negedge clk);
        n_chk++; if (o_done !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL end_idle sel=%0d got done=%b valid=%b want 0/0", sel, o_done, o_valid); end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            cur = s;
            #1;
            n_chk++;
            if ({o_valid, o_last, o_busy, o_done, o_ovf} !== 5'b0 || o_data !== 32'd0 || o_index !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_outputs sel=%0d got v=%b l=%b b=%b d=%b o=%b data=%0d idx=%0d want all 0",
                         s, o_valid, o_last, o_busy, o_done, o_ovf, o_data, o_index);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_default_seq();
        run_seq(0, 8, 100, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic test_fib();
        write_seed(1, 0, 32'd0);
        write_seed(1, 1, 32'd1);
        run_seq(1, 10, 100, 1'b0, 1'b0, 0, 32'd0);
        run_seq(1, 10, 100, 1'b0, 1'b0, 0, 32'd0);
        // Out-of-range slots are ignored; random seeds, and a write coinciding with start.
        write_seed(1, 2, $urandom);
        write_seed(1, 7, $urandom);
        write_seed(1, 1, $urandom_range(1000));
        run_seq(1, 12, 70, 1'b0, 1'b1, 0, 32'($urandom_range(1000)));
        run_seq(1, 12, 70, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic test_backpressure();
        run_seq(0, 8, 50, 1'b0, 1'b0, 0, 32'd0);
        write_seed(0, 0, $urandom);
        write_seed(0, 2, $urandom);
        run_seq(0, 20, 40, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic test_overflow();
        run_seq(2, 14, 100, 1'b0, 1'b0, 0, 32'd0);
        run_seq(2, 3, 100, 1'b0, 1'b0, 0, 32'd0);
        run_seq(2, 14, 60, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic test_len_zero();
        cur = 2;
        len = 16'd0;
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v = '0;
        n_chk++; if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL len0_done got done=%b valid=%b busy=%b want 1/0/0", o_done, o_valid, o_busy); end
        n_chk++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL len0_ovf_clear got %b want 0", o_ovf); end
        @(negedge clk);
        n_chk++; if (o_done !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL len0_after got done=%b valid=%b want 0/0", o_done, o_valid); end
    endtask

    task automatic test_abort();
        cur = 0;
        build_model(0, 10);
        len = 16'd10;
        s_ready = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        n_chk++; if (o_index !== 16'd4 || o_data !== 32'(exp_t[4])) begin n_fail++; $display("FAIL abort_pre got idx=%0d data=%0d want 4/%0d", o_index, o_data, exp_t[4]); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL abort_stop got valid=%b busy=%b done=%b want 0/0/0", o_valid, o_busy, o_done); end
        n_chk++; if (o_index !== 16'd5) begin n_fail++; $display("FAIL abort_beat_counted got idx=%0d want 5", o_index); end
        @(negedge clk);
        n_chk++; if (o_done !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL abort_nodone got done=%b valid=%b want 0/0", o_done, o_valid); end
        run_seq(0, 5, 100, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic test_start_in_run();
        run_seq(0, 8, 60, 1'b1, 1'b0, 0, 32'd0);
        run_seq(1, 9, 100, 1'b1, 1'b0, 0, 32'd0);
    endtask

    task automatic test_reset_midrun();
        cur = 0;
        len = 16'd8;
        s_ready = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        n_chk++; if (o_index !== 16'd5 || o_valid !== 1'b1) begin n_fail++; $display("FAIL midrun_pre got idx=%0d valid=%b want 5/1", o_index, o_valid); end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({o_valid, o_last, o_busy, o_done, o_ovf} !== 5'b0 || o_data !== 32'd0 || o_index !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_async got v=%b l=%b b=%b d=%b o=%b data=%0d idx=%0d want all 0",
                     o_valid, o_last, o_busy, o_done, o_ovf, o_data, o_index);
        end
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_seq(0, 4, 100, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int sel;
            sel = $urandom_range(2);
            if ($urandom_range(1)) write_seed(sel, $urandom_range(3), 32'($urandom_range(300)));
            run_seq(sel, $urandom_range(1, 25), $urandom_range(30, 100), 1'($urandom_range(1)),
                    1'($urandom_range(1)), $urandom_range(3), 32'($urandom_range(300)));
        end
    endtask

    initial begin
        rst       = 1'b0;
        start_v   = '0;
        seed_we_v = '0;
        abort     = 1'b0;
        len       = '0;
        seed_idx  = '0;
        seed_data = '0;
        s_ready   = 1'b0;
        cur       = 0;
        reset_model();

        test_reset();
        test_default_seq();
        test_fib();
        test_backpressure();
        test_overflow();
        test_len_zero();
        test_abort();
        test_start_in_run();
        test_reset_midrun();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
